// File: rtl/spi_adc_scheduler_pkg.sv
// Shared types for the SPI ADC scheduler: FSM states, grant IDs, ADC data width.
// Also holds the round-robin pick used by the request arbiter.
package spi_adc_scheduler_pkg;

    localparam int ADC_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_CAPTURE,
        ST_PRESENT
    } state_e;

    typedef enum logic {
        GNT_AUTO = 1'b0,
        GNT_MAN  = 1'b1
    } grant_e;

    // With both requesters pending, the one that did not win last time goes first.
    function automatic grant_e pick_grant(input logic pend_auto, input logic pend_man,
                                          input grant_e last_grant);
        if (pend_auto && pend_man) begin
            return (last_grant == GNT_AUTO) ? GNT_MAN : GNT_AUTO;
        end
        return pend_auto ? GNT_AUTO : GNT_MAN;
    endfunction

endpackage

// File: rtl/spi_adc_scheduler_if.sv
// Sample hand-off port (valid/ready) between the scheduler and its consumer.
interface spi_adc_scheduler_if;
    import spi_adc_scheduler_pkg::*;

    logic [ADC_W-1:0] sample_data;
    logic             sample_valid;
    logic             sample_ready;

    modport master (output sample_data, output sample_valid, input sample_ready);
    modport slave  (input sample_data, input sample_valid, output sample_ready);

endinterface

// File: rtl/spi_adc_tick_gen.sv
// Free-running PERIOD counter; emits a one-cycle tick on wrap while enabled,
// and parks at zero whenever the enable is low.
module spi_adc_tick_gen #(
    parameter int PERIOD = 16
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        tick  = en && (cnt_q == CNT_W'(PERIOD - 1));
        cnt_d = '0;
        if (en && !tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_adc_scheduler.sv
// Arbitrates timer/button requests, drives the SPI master's start and returns samples
// over a valid/ready port. Define SPI_ADC_AVG_EN to present 2^AVG_LOG2-sample averages.
module spi_adc_scheduler
    import spi_adc_scheduler_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SAMPLE_HZ = 1_000,
    parameter int TIMEOUT   = 4096,
    parameter int AVG_LOG2  = 2
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   btn_n,
    input  logic                   auto_en,
    output logic                   spi_start,
    input  logic                   spi_cs_n,
    input  logic [ADC_W-1:0]       spi_adc_data,
    spi_adc_scheduler_if.master    smp,
    output logic                   busy,
    output logic                   err_timeout,
    output logic                   overrun
);

    localparam int PERIOD = CLK_HZ / SAMPLE_HZ;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    grant_e           last_grant_q, last_grant_d;
    grant_e           grant_id;
    logic             pend_auto_q, pend_auto_d;
    logic             pend_man_q, pend_man_d;
    logic [1:0]       btn_sync_q, btn_sync_d;
    logic             btn_last_q, btn_last_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [ADC_W-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic             ovr_q, ovr_d;

    logic             auto_req, man_req;
    logic             grant_en, grant_auto, grant_man;
    logic             waiting, cs_edge, abort, accept;
    logic [ADC_W-1:0] capture_value;
    logic             capture_done;

    spi_adc_tick_gen #(.PERIOD(PERIOD)) u_tick_gen (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (auto_en),
        .tick  (auto_req)
    );

    // Button passes a 2-flop synchronizer; a 1->0 transition after it is one manual request.
    assign man_req = btn_last_q && !btn_sync_q[1];

    // Foreign cs_n activity in IDLE blocks new grants until the bus is released.
    assign grant_en   = (state_q == ST_IDLE) && spi_cs_n && (pend_auto_q || pend_man_q);
    assign grant_id   = pick_grant(pend_auto_q, pend_man_q, last_grant_q);
    assign grant_auto = grant_en && (grant_id == GNT_AUTO);
    assign grant_man  = grant_en && (grant_id == GNT_MAN);

    // A cs_n edge on the last allowed cycle counts as progress, not as a timeout.
    assign waiting = (state_q == ST_WAIT_LOW) || (state_q == ST_WAIT_HIGH);
    assign cs_edge = (state_q == ST_WAIT_LOW) ? !spi_cs_n : spi_cs_n;
    assign abort   = waiting && !cs_edge && (tmo_q == TMO_W'(TIMEOUT - 1));
    assign accept  = (state_q == ST_PRESENT) && smp.sample_ready;

    always_comb begin
        btn_sync_d   = {btn_sync_q[0], btn_n};
        btn_last_d   = btn_sync_q[1];
        last_grant_d = grant_en ? grant_id : last_grant_q;
        pend_auto_d  = (pend_auto_q && !grant_auto) || auto_req;
        pend_man_d   = (pend_man_q && !grant_man) || man_req;
        ovr_d        = ovr_q
                     || (auto_req && pend_auto_q && !grant_auto)
                     || (man_req && pend_man_q && !grant_man);

        state_d = state_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE:      if (grant_en) state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_WAIT_LOW;
            ST_WAIT_LOW,
            ST_WAIT_HIGH: begin
                if (cs_edge) begin
                    state_d = (state_q == ST_WAIT_LOW) ? ST_WAIT_HIGH : ST_CAPTURE;
                end else if (abort) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (capture_done) begin
                    data_d  = capture_value;
                    state_d = ST_PRESENT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (accept) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default:      state_d = ST_IDLE;
        endcase

        // Dwell counter restarts on every state change and only runs while waiting on cs_n.
        tmo_d = '0;
        if (state_d == state_q && waiting) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_AUTO;
            pend_auto_q  <= 1'b0;
            pend_man_q   <= 1'b0;
            btn_sync_q   <= 2'b11;
            btn_last_q   <= 1'b1;
            tmo_q        <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pend_auto_q  <= pend_auto_d;
            pend_man_q   <= pend_man_d;
            btn_sync_q   <= btn_sync_d;
            btn_last_q   <= btn_last_d;
            tmo_q        <= tmo_d;
            data_q       <= data_d;
            err_q        <= err_d;
            ovr_q        <= ovr_d;
        end
    end

`ifdef SPI_ADC_AVG_EN
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int AVG_N = 1 << AVG_LOG2;

    logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic [AVG_LOG2:0] avg_cnt_q, avg_cnt_d;

    // Intermediate captures only accumulate; the last one of a group is presented.
    always_comb begin
        acc_sum       = acc_q + ACC_W'(spi_adc_data);
        capture_done  = (avg_cnt_q == (AVG_LOG2 + 1)'(AVG_N - 1));
        capture_value = ADC_W'(acc_sum >> AVG_LOG2);
        acc_d         = acc_q;
        avg_cnt_d     = avg_cnt_q;
        if (state_q == ST_CAPTURE) begin
            acc_d     = acc_sum;
            avg_cnt_d = avg_cnt_q + 1'b1;
        end
        if (accept || abort) begin
            acc_d     = '0;
            avg_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_q     <= '0;
            avg_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            avg_cnt_q <= avg_cnt_d;
        end
    end
`else
    assign capture_value = spi_adc_data;
    assign capture_done  = 1'b1;
`endif

    assign spi_start        = (state_q == ST_ISSUE);
    assign busy             = (state_q != ST_IDLE);
    assign smp.sample_valid = (state_q == ST_PRESENT);
    assign smp.sample_data  = data_q;
    assign err_timeout      = err_q;
    assign overrun          = ovr_q;

endmodule

// File: tb/tb_spi_adc_scheduler.sv
// Randomized bench for spi_adc_scheduler with a behavioural SPI slave and a cycle-level
// reference model of the scheduling rules; honours SPI_ADC_AVG_EN like the design.
module tb_spi_adc_scheduler;
    import spi_adc_scheduler_pkg::*;

    localparam int PERIOD   = 16;
    localparam int TIMEOUT  = 40;
    localparam int AVG_LOG2 = 2;

    // Model stage numbering: conversion phases in the order a sample passes through them.
    localparam int P_IDLE = 0, P_ISSUE = 1, P_WLOW = 2, P_WHIGH = 3, P_CAPT = 4, P_PRES = 5;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       btn_n = 1'b1;
    logic       auto_en = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic [7:0] spi_adc_data = 8'h00;
    logic       spi_start, busy, err_timeout, overrun;

    spi_adc_scheduler_if sif ();

    spi_adc_scheduler #(
        .CLK_HZ    (PERIOD * 1000),
        .SAMPLE_HZ (1000),
        .TIMEOUT   (TIMEOUT),
        .AVG_LOG2  (AVG_LOG2)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .btn_n        (btn_n),
        .auto_en      (auto_en),
        .spi_start    (spi_start),
        .spi_cs_n     (spi_cs_n),
        .spi_adc_data (spi_adc_data),
        .smp          (sif.master),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus knobs
    int k_btn_pct, k_auto_toggle, k_ready_pct, k_noresp_pct, k_foreign_pm;
    int k_low_min, k_low_max, k_fixed_data;
    int data_q[$];

    // Behavioural SPI slave
    int sl_state, sl_cnt;

    // Reference model
    bit m_sync1, m_sync2, m_last, m_pa, m_pm, m_last_man, m_err, m_ovr;
    int m_tick, m_stage, m_dwell, m_data, m_acc, m_nacc;

    int valid_seen, last_valid_data;

    task automatic model_reset();
        m_sync1 = 1; m_sync2 = 1; m_last = 1;
        m_pa = 0; m_pm = 0; m_last_man = 0; m_err = 0; m_ovr = 0;
        m_tick = 0; m_stage = P_IDLE; m_dwell = 0; m_data = 0; m_acc = 0; m_nacc = 0;
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_step();
        bit man_ev, auto_ev, go, pick_man, progress;
        int nxt;
        man_ev  = m_last && !m_sync2;
        auto_ev = auto_en && (m_tick == PERIOD - 1);
        m_last  = m_sync2;
        m_sync2 = m_sync1;
        m_sync1 = btn_n;
        m_tick  = !auto_en ? 0 : (m_tick == PERIOD - 1) ? 0 : m_tick + 1;

        go       = (m_stage == P_IDLE) && spi_cs_n && (m_pa || m_pm);
        pick_man = m_pm && (!m_pa || !m_last_man);
        if (auto_ev && m_pa && !(go && !pick_man)) m_ovr = 1;
        if (man_ev && m_pm && !(go && pick_man)) m_ovr = 1;
        if (go) begin
            if (pick_man) m_pm = 0; else m_pa = 0;
            m_last_man = pick_man;
        end
        if (auto_ev) m_pa = 1;
        if (man_ev) m_pm = 1;

        nxt = m_stage;
        case (m_stage)
            P_IDLE:  if (go) nxt = P_ISSUE;
            P_ISSUE: nxt = P_WLOW;
            P_WLOW, P_WHIGH: begin
                progress = (m_stage == P_WLOW) ? !spi_cs_n : spi_cs_n;
                if (progress) nxt = m_stage + 1;
                else if (m_dwell == TIMEOUT - 1) begin
                    nxt = P_IDLE; m_err = 1; m_acc = 0; m_nacc = 0;
                end
            end
            P_CAPT: begin
`ifdef SPI_ADC_AVG_EN
                m_acc  += spi_adc_data;
                m_nacc += 1;
                if (m_nacc == (1 << AVG_LOG2)) begin
                    m_data = m_acc >> AVG_LOG2;
                    nxt = P_PRES;
                end else nxt = P_IDLE;
`else
                m_data = spi_adc_data;
                nxt = P_PRES;
`endif
            end
            default: if (sif.sample_ready) begin
                nxt = P_IDLE; m_err = 0; m_acc = 0; m_nacc = 0;
            end
        endcase
        m_dwell = (nxt != m_stage) ? 0 : m_dwell + 1;
        m_stage = nxt;
    endtask

    function automatic logic [7:0] next_data();
        if (data_q.size() > 0) return 8'(data_q.pop_front());
        if (k_fixed_data >= 0) return 8'(k_fixed_data);
        return 8'($urandom_range(255));
    endfunction

    task automatic drive_inputs();
        btn_n = ($urandom_range(99) < k_btn_pct) ? 1'b0 : 1'b1;
        if (k_auto_toggle != 0 && $urandom_range(199) == 0) auto_en = ~auto_en;
        sif.sample_ready = ($urandom_range(99) < k_ready_pct);
        case (sl_state)
            0: begin
                if (spi_start) begin
                    if ($urandom_range(99) >= k_noresp_pct) begin
                        sl_state = 1; sl_cnt = $urandom_range(4, 1);
                    end
                end else if ($urandom_range(999) < k_foreign_pm) begin
                    spi_cs_n = 1'b0; sl_state = 3; sl_cnt = $urandom_range(6, 1);
                end
            end
            1: begin
                sl_cnt--;
                if (sl_cnt == 0) begin
                    spi_cs_n = 1'b0; sl_state = 2; sl_cnt = $urandom_range(k_low_max, k_low_min);
                end
            end
            2: begin
                sl_cnt--;
                if (sl_cnt == 0) begin
                    spi_cs_n = 1'b1; spi_adc_data = next_data(); sl_state = 0;
                end
            end
            default: begin
                sl_cnt--;
                if (sl_cnt == 0) begin
                    spi_cs_n = 1'b1; sl_state = 0;
                end
            end
        endcase
    endtask

    // Called at a falling edge: compare, drive this cycle's inputs, predict, move on.
    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            check("spi_start", spi_start, m_stage == P_ISSUE);
            check("busy", busy, m_stage != P_IDLE);
            check("sample_valid", sif.sample_valid, m_stage == P_PRES);
            check("sample_data", sif.sample_data, m_data);
            check("err_timeout", err_timeout, m_err);
            check("overrun", overrun, m_ovr);
            check("last_grant", dut.last_grant_q, m_last_man);
            if (sif.sample_valid === 1'b1) begin
                valid_seen++;
                last_valid_data = sif.sample_data;
            end
            drive_inputs();
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic set_knobs(input int btn, input int auto_on, input int tog, input int rdy,
                             input int noresp, input int lo_min, input int lo_max, input int fixed);
        k_btn_pct = btn; auto_en = auto_on[0]; k_auto_toggle = tog; k_ready_pct = rdy;
        k_noresp_pct = noresp; k_low_min = lo_min; k_low_max = lo_max; k_fixed_data = fixed;
        k_foreign_pm = 0;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        btn_n = 1'b1; auto_en = 1'b0; spi_cs_n = 1'b1; sif.sample_ready = 1'b0;
        sl_state = 0; sl_cnt = 0;
        data_q.delete();
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        model_reset();
        valid_seen = 0;
    endtask

    task automatic press_btn();
        k_btn_pct = 100;
        cycle(2);
        k_btn_pct = 0;
        cycle(40);
    endtask

    initial begin
        bit found;
        sif.sample_ready = 1'b0;
        set_knobs(0, 0, 0, 0, 0, 1, 1, -1);
        repeat (2) @(negedge clk);
        check("rst_spi_start", spi_start, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", sif.sample_valid, 0);
        check("rst_data", sif.sample_data, 0);
        check("rst_err", err_timeout, 0);
        check("rst_overrun", overrun, 0);

        // Periodic trigger, 20-cycle conversions returning A5
        do_reset();
        set_knobs(0, 1, 0, 100, 0, 20, 20, 8'hA5);
        cycle(160);
        check("t1_data", sif.sample_data, 8'hA5);
        check("t1_samples", valid_seen > 0, 1);

        // Both requesters pending behind foreign cs_n activity: manual wins first
        do_reset();
        set_knobs(0, 1, 0, 100, 0, 20, 20, -1);
        spi_cs_n = 1'b0; sl_state = 3; sl_cnt = 40;
        cycle(3);
        k_btn_pct = 100;
        cycle(4);
        k_btn_pct = 0;
        cycle(38);
        check("t2_first_grant", dut.last_grant_q, GNT_MAN);
        cycle(55);
        check("t2_second_grant", dut.last_grant_q, GNT_AUTO);
        check("t2_overrun", overrun, 1);

        // Unanswered start: timeout abort, then cleared by the next accepted sample
        do_reset();
        set_knobs(0, 0, 0, 100, 100, 5, 5, -1);
        press_btn();
        cycle(TIMEOUT);
        check("t3_err", err_timeout, 1);
        check("t3_busy", busy, 0);
        check("t3_no_sample", valid_seen, 0);
        k_noresp_pct = 0;
        repeat (1 << AVG_LOG2) press_btn();
        check("t3_err_cleared", err_timeout, 0);

        // Backpressure: sample held, further ticks only pend and flag overrun
        do_reset();
        set_knobs(0, 1, 0, 0, 0, 5, 5, 8'h3C);
        cycle(150);
        check("t4_valid_held", sif.sample_valid, 1);
        check("t4_data", sif.sample_data, 8'h3C);
        check("t4_overrun", overrun, 1);
        k_ready_pct = 100;
        cycle(120);

        // Asynchronous reset while waiting for cs_n to rise
        do_reset();
        set_knobs(0, 1, 0, 100, 0, 20, 20, -1);
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (m_stage == P_WHIGH && m_dwell > 2) found = 1;
            else cycle(1);
        end
        check("t5_reach_wait_high", found, 1);
        check("t5_busy_before", busy, 1);
        #1 n_rst = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_start", spi_start, 0);
        check("t5_valid", sif.sample_valid, 0);
        check("t5_err", err_timeout, 0);
        check("t5_overrun", overrun, 0);
        do_reset();
        set_knobs(0, 1, 0, 100, 0, 3, 8, -1);
        cycle(100);

`ifdef SPI_ADC_AVG_EN
        // Four captures averaged into one sample: (10+20+30+41)/4 truncates to 25
        do_reset();
        set_knobs(0, 0, 0, 100, 0, 3, 3, -1);
        data_q = '{10, 20, 30, 41};
        repeat (4) press_btn();
        check("t6_valid_count", valid_seen, 1);
        check("t6_avg", last_valid_data, 25);
`endif

        // Free-running random traffic
        do_reset();
        set_knobs(5, 1, 1, 60, 10, 1, 45, -1);
        k_foreign_pm = 5;
        cycle(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
